// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback unit: register-file geometry and
// the long-latency result entry carried through the LL FIFO.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // True when a nonzero register address matches another address.
    function automatic logic rd_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Synchronous FIFO of long-latency results. Pointers carry one extra wrap bit
// so that full and empty are distinguishable without a separate count.
module wb_ll_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        head = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/wb_writeback_unit.sv
// Register-file write-port arbiter merging the in-order pipe stream with queued
// long-latency results, plus LL busy scoreboard. Optional: WB_BYPASS_EN.
module wb_writeback_unit
    import wb_pkg::*;
#(
    parameter int LL_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  ll_issue,
    input  logic [REG_ADDR_W-1:0] ll_issue_rd,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    input  logic [XLEN-1:0]       ll_data,
    output logic                  rf_reg_write,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_write_data,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    output logic                  id_hazard,
    output logic                  wb_stall
`ifdef WB_BYPASS_EN
    ,
    output logic                  id_rs1_fwd,
    output logic                  id_rs2_fwd,
    output logic [XLEN-1:0]       id_rs1_fwd_data,
    output logic [XLEN-1:0]       id_rs2_fwd_data
`endif
);

    localparam logic [REG_ADDR_W-1:0] STARVE_MAX = REG_ADDR_W'(STARVE_LIMIT);

    wb_entry_t             fifo_head, fifo_in;
    logic                  fifo_full, fifo_empty;
    logic                  ll_push, ll_pop, sel_pipe;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  rf_reg_write_q, rf_reg_write_d;
    logic [REG_ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [XLEN-1:0]       rf_write_data_q, rf_write_data_d;
    logic                  wb_stall_q, wb_stall_d;
    logic [REG_ADDR_W-1:0] starve_q, starve_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  busy_hit;

    // Ready ignores any same-cycle pop, so a full FIFO never accepts.
    assign ll_ready = rst_n && !fifo_full;
    assign ll_push  = ll_valid && ll_ready;
    assign fifo_in  = '{rd: ll_rd, data: ll_data};

    wb_ll_fifo #(.DEPTH(LL_DEPTH)) u_ll_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ll_push),
        .push_entry (fifo_in),
        .pop        (ll_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        sel_pipe = !wb_stall_q && pipe_valid;
        ll_pop   = !sel_pipe && !fifo_empty;
        sel_rd   = sel_pipe ? pipe_rd : fifo_head.rd;
        sel_data = sel_pipe ? pipe_data : fifo_head.data;

        rf_reg_write_d  = (sel_pipe || ll_pop) && (sel_rd != '0);
        rf_rd_addr_d    = rf_rd_addr_q;
        rf_write_data_d = rf_write_data_q;
        if (rf_reg_write_d) begin
            rf_rd_addr_d    = sel_rd;
            rf_write_data_d = sel_data;
        end
    end

    // The stall lands on the same edge the counter saturates, and the stall
    // cycle always pops, so it self-clears after one cycle.
    always_comb begin
        if (fifo_empty || ll_pop)
            starve_d = '0;
        else if (starve_q != STARVE_MAX)
            starve_d = starve_q + 5'd1;
        else
            starve_d = starve_q;
        wb_stall_d = (starve_d == STARVE_MAX);
    end

    always_comb begin
        busy_d = busy_q;
        if (ll_pop && fifo_head.rd != '0) busy_d[fifo_head.rd] = 1'b0;
        if (ll_issue && ll_issue_rd != '0) busy_d[ll_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write_q  <= 1'b0;
            rf_rd_addr_q    <= '0;
            rf_write_data_q <= '0;
            wb_stall_q      <= 1'b0;
            starve_q        <= '0;
            busy_q          <= '0;
        end else begin
            rf_reg_write_q  <= rf_reg_write_d;
            rf_rd_addr_q    <= rf_rd_addr_d;
            rf_write_data_q <= rf_write_data_d;
            wb_stall_q      <= wb_stall_d;
            starve_q        <= starve_d;
            busy_q          <= busy_d;
        end
    end

    assign rf_reg_write  = rf_reg_write_q;
    assign rf_rd_addr    = rf_rd_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign wb_stall      = wb_stall_q;

    assign busy_hit = (id_rs1_addr != '0 && busy_q[id_rs1_addr]) ||
                      (id_rs2_addr != '0 && busy_q[id_rs2_addr]) ||
                      (id_rd_addr  != '0 && busy_q[id_rd_addr]);

`ifdef WB_BYPASS_EN
    always_comb begin
        id_rs1_fwd      = rf_reg_write_q && rd_hit(rf_rd_addr_q, id_rs1_addr);
        id_rs2_fwd      = rf_reg_write_q && rd_hit(rf_rd_addr_q, id_rs2_addr);
        id_rs1_fwd_data = rf_write_data_q;
        id_rs2_fwd_data = rf_write_data_q;
        id_hazard       = busy_hit;
    end
`else
    always_comb begin
        id_hazard = busy_hit ||
                    (rf_reg_write_q && (rd_hit(rf_rd_addr_q, id_rs1_addr) ||
                                        rd_hit(rf_rd_addr_q, id_rs2_addr)));
    end
`endif

    // Re-issuing to a busy rd is only legal when that rd's result pops this cycle.
    ll_issue_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(ll_issue && ll_issue_rd != '0 && busy_q[ll_issue_rd] &&
          !(ll_pop && fifo_head.rd == ll_issue_rd)));

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit: expected RF writes are queued as
// stimulus is driven and compared whenever the write strobe is seen.
module tb_wb_writeback_unit;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        ll_issue = 1'b0;
    logic [4:0]  ll_issue_rd = '0;
    logic        ll_valid = 1'b0;
    logic        ll_ready;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_data = '0;
    logic        rf_reg_write;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  id_rs1_addr = '0;
    logic [4:0]  id_rs2_addr = '0;
    logic [4:0]  id_rd_addr = '0;
    logic        id_hazard;
    logic        wb_stall;
`ifdef WB_BYPASS_EN
    logic        id_rs1_fwd, id_rs2_fwd;
    logic [31:0] id_rs1_fwd_data, id_rs2_fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    wb_entry_t exp_q[$];
    wb_entry_t llq[$];

    always #5 clk = ~clk;

    wb_writeback_unit #(.LL_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_valid    (pipe_valid),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .ll_issue      (ll_issue),
        .ll_issue_rd   (ll_issue_rd),
        .ll_valid      (ll_valid),
        .ll_ready      (ll_ready),
        .ll_rd         (ll_rd),
        .ll_data       (ll_data),
        .rf_reg_write  (rf_reg_write),
        .rf_rd_addr    (rf_rd_addr),
        .rf_write_data (rf_write_data),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_hazard     (id_hazard),
        .wb_stall      (wb_stall)
`ifdef WB_BYPASS_EN
        ,
        .id_rs1_fwd      (id_rs1_fwd),
        .id_rs2_fwd      (id_rs2_fwd),
        .id_rs1_fwd_data (id_rs1_fwd_data),
        .id_rs2_fwd_data (id_rs2_fwd_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_entry_t mk(input logic [4:0] rd, input logic [31:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

    // Every observed RF write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rf_reg_write) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(rf_reg_write), 32'd0);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                check_eq("wb_rd", 32'(rf_rd_addr), 32'(e.rd));
                check_eq("wb_data", rf_write_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_stall;
        int waits;
        int k;
        bit held;

        #12;
        check_eq("rst_reg_write", 32'(rf_reg_write), 32'd0);
        check_eq("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
        check_eq("rst_wdata", rf_write_data, 32'd0);
        check_eq("rst_stall", 32'(wb_stall), 32'd0);
        check_eq("rst_ll_ready", 32'(ll_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_rst", 32'(ll_ready), 32'd1);

        // First pipe write, one-cycle latency
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
        #1 check_eq("pre_first_write", 32'(rf_reg_write), 32'd0);
        tick();
        pipe_valid = 1'b0;
        check_eq("first_strobe", 32'(rf_reg_write), 32'd1);
        tick();

        // LL busy hazard and two-cycle LL latency
        ll_issue = 1'b1; ll_issue_rd = 5'd7;
        tick();
        ll_issue = 1'b0; id_rs1_addr = 5'd7;
        #1 check_eq("busy_hazard", 32'(id_hazard), 32'd1);
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
        exp_q.push_back(mk(5'd7, 32'h1234));
        tick();
        ll_valid = 1'b0;
        check_eq("ll_lat1", 32'(rf_reg_write), 32'd0);
        check_eq("ll_lat1_hazard", 32'(id_hazard), 32'd1);
        tick();
        check_eq("ll_lat2", 32'(rf_reg_write), 32'd1);
`ifdef WB_BYPASS_EN
        check_eq("ll_lat2_hazard", 32'(id_hazard), 32'd0);
        check_eq("rs1_fwd", 32'(id_rs1_fwd), 32'd1);
        check_eq("rs1_fwd_data", id_rs1_fwd_data, 32'h1234);
`else
        check_eq("ll_lat2_hazard", 32'(id_hazard), 32'd1);
`endif
        tick();
        check_eq("hazard_clear", 32'(id_hazard), 32'd0);
        id_rs1_addr = '0;

        // Starvation with a continuously busy pipe
        n_stall = 0; waits = 0; k = 0; held = 1'b0;
        pipe_valid = 1'b1;
        for (int c = 0; c < 30 && n_stall < 2; c++) begin
            if (wb_stall) begin
                n_stall++;
                check_eq("starve_wait", 32'(waits), 32'd4);
                waits = 0;
                if (llq.size() == 0) check_eq("stall_without_ll", 32'(wb_stall), 32'd0);
                else exp_q.push_back(llq.pop_front());
                k++;
                pipe_rd = 5'(10 + (k % 8)); pipe_data = 32'hA000_0000 + 32'(k);
                held = 1'b1;
            end else begin
                if (!held) begin
                    k++;
                    pipe_rd = 5'(10 + (k % 8)); pipe_data = 32'hA000_0000 + 32'(k);
                end
                held = 1'b0;
                exp_q.push_back(mk(pipe_rd, pipe_data));
                if (c >= 1) waits++;
            end
            if (c == 0) begin
                ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 32'hB000_0001;
                llq.push_back(mk(5'd20, 32'hB000_0001));
            end else if (c == 1) begin
                ll_rd = 5'd21; ll_data = 32'hB000_0002;
                llq.push_back(mk(5'd21, 32'hB000_0002));
            end else begin
                if (c == 2) check_eq("fifo_full_ready", 32'(ll_ready), 32'd0);
                ll_rd = 5'd22; ll_data = 32'h0000_C0DE;
                ll_valid = !ll_ready;
            end
            tick();
        end
        check_eq("stall_count", 32'(n_stall), 32'd2);
        pipe_valid = 1'b0; ll_valid = 1'b0;
        repeat (6) tick();
        check_eq("ready_after_drain", 32'(ll_ready), 32'd1);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        // rd==0 writes are dropped but consumed
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55;
        ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h66;
        tick();
        pipe_valid = 1'b0;
        ll_rd = 5'd12; ll_data = 32'h0C0C;
        exp_q.push_back(mk(5'd12, 32'h0C0C));
        check_eq("rd0_pipe_drop", 32'(rf_reg_write), 32'd0);
        tick();
        ll_valid = 1'b0;
        check_eq("rd0_ll_drop", 32'(rf_reg_write), 32'd0);
        tick();
        check_eq("ll_after_rd0", 32'(rf_reg_write), 32'd1);
        tick();

        // Issue to rd 9 on the same cycle its result pops: busy must stay set
        ll_issue = 1'b1; ll_issue_rd = 5'd9;
        tick();
        ll_issue = 1'b0;
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9999;
        exp_q.push_back(mk(5'd9, 32'h9999));
        tick();
        ll_valid = 1'b0;
        ll_issue = 1'b1; ll_issue_rd = 5'd9;
        tick();
        ll_issue = 1'b0;
        check_eq("rd9_strobe", 32'(rf_reg_write), 32'd1);
        id_rs2_addr = 5'd9;
        tick();
        check_eq("rd9_idle", 32'(rf_reg_write), 32'd0);
        check_eq("busy9_kept", 32'(id_hazard), 32'd1);
        id_rs2_addr = '0;

        // Reset mid-operation with queued LL results and busy[3]
        ll_issue = 1'b1; ll_issue_rd = 5'd3;
        tick();
        ll_issue = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd13; pipe_data = 32'hD0;
        exp_q.push_back(mk(5'd13, 32'hD0));
        ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h3333;
        tick();
        pipe_data = 32'hD1;
        exp_q.push_back(mk(5'd13, 32'hD1));
        ll_rd = 5'd4; ll_data = 32'h4444;
        tick();
        ll_valid = 1'b0;
        id_rd_addr = 5'd3;
        #1 check_eq("s6_full", 32'(ll_ready), 32'd0);
        check_eq("waw_hazard", 32'(id_hazard), 32'd1);
        rst_n = 1'b0;
        pipe_valid = 1'b0;
        #1;
        check_eq("async_rst_write", 32'(rf_reg_write), 32'd0);
        check_eq("async_rst_addr", 32'(rf_rd_addr), 32'd0);
        check_eq("async_rst_data", rf_write_data, 32'd0);
        check_eq("async_rst_stall", 32'(wb_stall), 32'd0);
        check_eq("async_rst_ready", 32'(ll_ready), 32'd0);
        check_eq("async_rst_hazard", 32'(id_hazard), 32'd0);
        exp_q.delete();
        id_rd_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        id_rs1_addr = 5'd3; id_rs2_addr = 5'd9;
        #1 check_eq("busy_cleared_by_rst", 32'(id_hazard), 32'd0);
        check_eq("ready_after_rst2", 32'(ll_ready), 32'd1);
        id_rs1_addr = '0; id_rs2_addr = '0;
        repeat (6) tick();
        ll_valid = 1'b1; ll_rd = 5'd14; ll_data = 32'h1414;
        exp_q.push_back(mk(5'd14, 32'h1414));
        tick();
        ll_valid = 1'b0;
        tick();
        check_eq("post_rst_ll", 32'(rf_reg_write), 32'd1);
        tick();
        check_eq("sb_final", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
